sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Parametrised N-channel request arbiter between the clients (Hack CPU, VGA scan-out, future DMA) and the `ram_manager` SDRAM request buffer. It replaces the fixed two-way display/CPU mux. It adds:
- selectable fixed-priority or round-robin arbitration,
- a high-priority display window,
- per-channel grant handshakes,
- in-order routing of read data back to the requesting channel through a tag FIFO.

## Interface
Parameters:
- `NCH`, 2: number of requester channels (2..8).
- `AW`, 20: address width.
- `DW`, 16: data width.
- `MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `HP_CH`, 0: index of the high-priority (display) channel.
- `HP_EXCL`, 1: 1 = while `hp_en` is high, only `HP_CH` is eligible; 0 = `HP_CH` merely wins first.
- `RD_DEPTH`, 4: read-tag FIFO depth, power of two, at least 2.

Ports:
- `clk50`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, NCH: per-channel request level. Held until granted.
- `req_rw`, in, NCH: per channel, 1 = write, 0 = read.
- `req_addr`, in, NCH*AW: channel i uses bits [i*AW +: AW].
- `req_data`, in, NCH*DW: write data per channel.
- `hp_en`, in, 1: display window active (`inDisplayArea`).
- `gnt`, out, NCH: one-cycle grant pulse. The channel may change its request fields on the next cycle.
- `buf_empty`, in, 1: `ram_manager` request buffer is empty.
- `buf_wrreq`, out, 1: one-cycle push into the request buffer.
- `buf_addr`, out, AW: registered request address.
- `buf_data`, out, DW: registered write data.
- `buf_rw`, out, 1: registered request direction.
- `rd_valid`, in, 1: one-cycle pulse, read data returned in request order.
- `rd_data`, in, DW: returned read data.
- `rsp_valid`, out, NCH: one-hot, one-cycle pulse to the channel that owns the returned read.
- `rsp_data`, out, DW: registered read data.
- `rd_err`, out, 1: sticky flag. Set when `rd_valid` arrives with the tag FIFO empty.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, tag FIFO empty, `rd_err` 0.
- Eligibility: channel i is eligible when all of the following hold:
  - `req[i]` is high;
  - either `req_rw[i]` = 1, or the tag FIFO is not full;
  - either `HP_EXCL` = 0, or `hp_en` = 0, or i = `HP_CH`.
- Winner selection:
  - If `hp_en` = 1 and `HP_CH` is eligible, `HP_CH` wins.
  - Otherwise, in `MODE` 0 the lowest eligible index wins.
  - Otherwise, in `MODE` 1 the first eligible index at or after the pointer wins, wrapping modulo `NCH`. The pointer then moves to winner+1, wrapping. The pointer does not move on an `HP_CH` override.
- State machine:
  - **IDLE**: when `buf_empty` = 1 and any channel is eligible:
    - register the winner's addr/data/rw onto `buf_*`;
    - pulse `buf_wrreq` and `gnt[winner]` in the same cycle;
    - if the request is a read, push the winner index into the tag FIFO;
    - go to SETTLE.
  - **SETTLE**: one cycle, with no issue. This absorbs the latency of `buf_empty`. Then return to IDLE.
  - `buf_*` fields hold their value between issues.
- Read return:
  - `rd_valid` pops the FIFO head.
  - The next cycle, `rsp_valid[head]` = 1 and `rsp_data` = `rd_data`.
  - A push and a pop in the same cycle are both honoured, and the occupancy is unchanged.
- `rd_valid` with the FIFO empty: no pop, no `rsp_valid`, and `rd_err` is set until reset.
- A full FIFO blocks only reads. Writes from other channels may still win.
- `hp_en` changing while in SETTLE: no effect until the next IDLE evaluation.
- `reset` asserted mid-operation:
  - all state clears immediately;
  - outstanding tags are discarded;
  - `rd_valid` arriving after reset sets `rd_err`.

## Timing
- Request to grant: one cycle minimum. The grant is registered from the IDLE evaluation of `req`.
- Issue rate: at most one request every 2 cycles.
- `gnt` and `buf_wrreq` are coincident one-cycle pulses.
- `rd_valid` to `rsp_valid`: 1 cycle.
- At most one `gnt` bit and at most one `rsp_valid` bit are high in any cycle.

## Test plan
- **Priority, `MODE` 0, `NCH` 3:** `buf_empty` held 1; channels 1 and 2 request writes continuously; `hp_en` = 0 → `gnt[1]` every 2 cycles, `gnt[2]` never; `buf_wrreq` carries channel 1's addr/data.
- **Round-robin, `MODE` 1, `NCH` 3:** all three channels request continuously → grant order 0, 1, 2, 0, … at 2-cycle spacing.
- **Display window, `HP_EXCL` 1, `NCH` 2:** CPU (ch1) writes 0x0123 to 0x00400 with `hp_en` = 1 → no `gnt[1]` while `hp_en` = 1. Drop `hp_en` → `gnt[1]` and `buf_wrreq` with addr 0x00400, data 0x0123, rw 1.
- **Read routing, `NCH` 3:** reads issued from ch2 then ch0; return 0xBEEF then 0x1234 → `rsp_valid` = 3'b100 with 0xBEEF, then 3'b001 with 0x1234, each 1 cycle after its `rd_valid`.
- **Tag FIFO full, `RD_DEPTH` 4, `NCH` 2:** 4 reads outstanding; ch0 read and ch1 write pending → only ch1 granted. A `rd_valid` with a simultaneous new read push keeps occupancy at 4.
- **Error and reset:** `rd_valid` with FIFO empty → `rd_err` = 1 and no `rsp_valid`. Assert `reset` low mid-SETTLE → all outputs 0 asynchronously and `rd_err` cleared.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Client-side request/grant bus and ram_manager buffer bus of the SDRAM port arbiter.
// master is the arbiter's view; slave is the view of the clients and ram_manager.
interface sdram_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 20,
  parameter int DW  = 16
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    req_rw;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_data;
  logic              hp_en;
  logic [NCH-1:0]    gnt;
  logic              buf_empty;
  logic              buf_wrreq;
  logic [AW-1:0]     buf_addr;
  logic [DW-1:0]     buf_data;
  logic              buf_rw;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rd_err;

  modport master (
    input  req, req_rw, req_addr, req_data, hp_en, buf_empty, rd_valid, rd_data,
    output gnt, buf_wrreq, buf_addr, buf_data, buf_rw, rsp_valid, rsp_data, rd_err
  );

  modport slave (
    output req, req_rw, req_addr, req_data, hp_en, buf_empty, rd_valid, rd_data,
    input  gnt, buf_wrreq, buf_addr, buf_data, buf_rw, rsp_valid, rsp_data, rd_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-channel arbiter feeding the ram_manager request buffer; read data is routed
// back to its requester in order through a tag FIFO of channel indices.
module sdram_port_arbiter #(
  parameter int NCH      = 2,
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int MODE     = 0,
  parameter int HP_CH    = 0,
  parameter int HP_EXCL  = 1,
  parameter int RD_DEPTH = 4
) (
  input logic                  clk50,
  input logic                  reset,
  sdram_port_arbiter_if.master bus
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = $clog2(RD_DEPTH);

  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] tag_mem [RD_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty;
  logic [IW-1:0] head;
  logic [NCH-1:0] elig;
  logic [IW-1:0] win;
  logic          win_vld, hp_win, issue, push, pop;
  int            rr_idx;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = tag_mem[rd_ptr[PW-1:0]];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++)
      elig[i] = bus.req[i] && (bus.req_rw[i] || !fifo_full) &&
                ((HP_EXCL == 0) || !bus.hp_en || (i == HP_CH));
  end

  // Descending scans leave the first match in priority order as the winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    hp_win  = 1'b0;
    rr_idx  = 0;
    if (bus.hp_en && elig[HP_CH]) begin
      win     = IW'(HP_CH);
      win_vld = 1'b1;
      hp_win  = 1'b1;
    end else if (MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (elig[i]) begin
          win     = IW'(i);
          win_vld = 1'b1;
        end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        rr_idx = (int'(rr_ptr) + k) % NCH;
        if (elig[rr_idx]) begin
          win     = IW'(rr_idx);
          win_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // SETTLE gives buf_empty a cycle to reflect the push just made.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.buf_empty && win_vld) begin
          issue     = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign push = issue && !bus.req_rw[win];
  assign pop  = bus.rd_valid && !fifo_empty;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      bus.gnt       <= '0;
      bus.buf_wrreq <= 1'b0;
      bus.buf_addr  <= '0;
      bus.buf_data  <= '0;
      bus.buf_rw    <= 1'b0;
      rr_ptr        <= '0;
    end else begin
      bus.gnt       <= '0;
      bus.buf_wrreq <= issue;
      if (issue) begin
        bus.gnt[win] <= 1'b1;
        bus.buf_addr <= bus.req_addr[int'(win)*AW +: AW];
        bus.buf_data <= bus.req_data[int'(win)*DW +: DW];
        bus.buf_rw   <= bus.req_rw[win];
        // The display override does not consume the round-robin turn.
        if ((MODE != 0) && !hp_win)
          rr_ptr <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rd_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      bus.rsp_valid <= '0;
      if (pop) begin
        bus.rsp_valid[head] <= 1'b1;
        bus.rsp_data        <= bus.rd_data;
      end
      if (bus.rd_valid && fifo_empty) bus.rd_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: it is only read while the FIFO is non-empty.
  always_ff @(posedge clk50) begin
    if (push) tag_mem[wr_ptr[PW-1:0]] <= win;
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Two arbiter configurations (fixed priority / exclusive window, and round-robin /
// non-exclusive window) checked cycle by cycle against a queue-based model.
module tb_sdram_port_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int DEPTH = 4;
  localparam int MODE_OF [2] = '{0, 1};
  localparam int HPCH_OF [2] = '{0, 2};
  localparam int EXCL_OF [2] = '{1, 0};

  logic clk50 = 1'b0;
  logic reset = 1'b0;
  always #5 clk50 = ~clk50;

  logic [NCH-1:0]    req_d  [2];
  logic [NCH-1:0]    rw_d   [2];
  logic [NCH*AW-1:0] addr_d [2];
  logic [NCH*DW-1:0] data_d [2];
  logic              hp_d   [2];
  logic              be_d   [2];
  logic              rv_d   [2];
  logic [DW-1:0]     rdat_d [2];

  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus0 ();
  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus1 ();

  assign bus0.req = req_d[0];   assign bus1.req = req_d[1];
  assign bus0.req_rw = rw_d[0]; assign bus1.req_rw = rw_d[1];
  assign bus0.req_addr = addr_d[0]; assign bus1.req_addr = addr_d[1];
  assign bus0.req_data = data_d[0]; assign bus1.req_data = data_d[1];
  assign bus0.hp_en = hp_d[0];  assign bus1.hp_en = hp_d[1];
  assign bus0.buf_empty = be_d[0]; assign bus1.buf_empty = be_d[1];
  assign bus0.rd_valid = rv_d[0];  assign bus1.rd_valid = rv_d[1];
  assign bus0.rd_data = rdat_d[0]; assign bus1.rd_data = rdat_d[1];

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(MODE_OF[0]), .HP_CH(HPCH_OF[0]),
                       .HP_EXCL(EXCL_OF[0]), .RD_DEPTH(DEPTH))
    dut0 (.clk50(clk50), .reset(reset), .bus(bus0));
  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(MODE_OF[1]), .HP_CH(HPCH_OF[1]),
                       .HP_EXCL(EXCL_OF[1]), .RD_DEPTH(DEPTH))
    dut1 (.clk50(clk50), .reset(reset), .bus(bus1));

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding reads as an ordered list of owner channels.
  int            busy [2];
  int            ptr  [2];
  int            tags [2][8];
  int            cnt  [2];
  logic [NCH-1:0] e_gnt  [2];
  logic          e_wrreq [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_data [2];
  logic          e_rw   [2];
  logic [NCH-1:0] e_rsp [2];
  logic [DW-1:0] e_rdat [2];
  logic          e_err  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      busy[m] = 0; ptr[m] = 0; cnt[m] = 0;
      e_gnt[m] = '0; e_wrreq[m] = 1'b0; e_addr[m] = '0; e_data[m] = '0; e_rw[m] = 1'b0;
      e_rsp[m] = '0; e_rdat[m] = '0; e_err[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    bit el [NCH];
    bit found, hpw, do_push;
    int w, idx;
    found = 0; hpw = 0; do_push = 0; w = 0;
    e_gnt[m] = '0; e_wrreq[m] = 1'b0; e_rsp[m] = '0;
    if (busy[m] == 0 && be_d[m]) begin
      for (int i = 0; i < NCH; i++)
        el[i] = req_d[m][i] && (rw_d[m][i] || cnt[m] < DEPTH) &&
                (EXCL_OF[m] == 0 || !hp_d[m] || i == HPCH_OF[m]);
      if (hp_d[m] && el[HPCH_OF[m]]) begin
        w = HPCH_OF[m]; found = 1; hpw = 1;
      end else if (MODE_OF[m] == 0) begin
        for (int i = 0; i < NCH; i++) if (!found && el[i]) begin w = i; found = 1; end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          idx = (ptr[m] + k) % NCH;
          if (!found && el[idx]) begin w = idx; found = 1; end
        end
      end
      if (found) begin
        e_gnt[m][w] = 1'b1;
        e_wrreq[m]  = 1'b1;
        e_addr[m]   = addr_d[m][w*AW +: AW];
        e_data[m]   = data_d[m][w*DW +: DW];
        e_rw[m]     = rw_d[m][w];
        do_push     = !rw_d[m][w];
        if (MODE_OF[m] == 1 && !hpw) ptr[m] = (w + 1) % NCH;
      end
    end
    busy[m] = found ? 1 : 0;
    if (rv_d[m]) begin
      if (cnt[m] > 0) begin
        e_rsp[m][tags[m][0]] = 1'b1;
        e_rdat[m] = rdat_d[m];
        for (int j = 0; j < 7; j++) tags[m][j] = tags[m][j+1];
        cnt[m]--;
      end else begin
        e_err[m] = 1'b1;
      end
    end
    if (do_push) begin
      tags[m][cnt[m]] = w;
      cnt[m]++;
    end
  endtask

  task automatic check_outputs(input int m);
    logic [NCH-1:0] g, rv;
    logic wr, rw, er;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    if (m == 0) begin
      g = bus0.gnt; wr = bus0.buf_wrreq; a = bus0.buf_addr; d = bus0.buf_data; rw = bus0.buf_rw;
      rv = bus0.rsp_valid; rd = bus0.rsp_data; er = bus0.rd_err;
    end else begin
      g = bus1.gnt; wr = bus1.buf_wrreq; a = bus1.buf_addr; d = bus1.buf_data; rw = bus1.buf_rw;
      rv = bus1.rsp_valid; rd = bus1.rsp_data; er = bus1.rd_err;
    end
    chk($sformatf("dut%0d gnt", m),       32'(g),  32'(e_gnt[m]));
    chk($sformatf("dut%0d buf_wrreq", m), 32'(wr), 32'(e_wrreq[m]));
    chk($sformatf("dut%0d buf_addr", m),  32'(a),  32'(e_addr[m]));
    chk($sformatf("dut%0d buf_data", m),  32'(d),  32'(e_data[m]));
    chk($sformatf("dut%0d buf_rw", m),    32'(rw), 32'(e_rw[m]));
    chk($sformatf("dut%0d rsp_valid", m), 32'(rv), 32'(e_rsp[m]));
    chk($sformatf("dut%0d rsp_data", m),  32'(rd), 32'(e_rdat[m]));
    chk($sformatf("dut%0d rd_err", m),    32'(er), 32'(e_err[m]));
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk50);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic set_req(input int m, input int ch, input logic on, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_d[m][ch] = on;
    rw_d[m][ch]  = rw;
    addr_d[m][ch*AW +: AW] = a;
    data_d[m][ch*DW +: DW] = d;
  endtask

  task automatic set_both(input int ch, input logic on, input logic rw,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(0, ch, on, rw, a, d);
    set_req(1, ch, on, rw, a, d);
  endtask

  task automatic issue_once(input int ch, input logic rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    bit seen [2];
    seen[0] = 0; seen[1] = 0;
    set_both(ch, 1'b1, rw, a, d);
    for (int k = 0; k < 8 && !(seen[0] && seen[1]); k++) begin
      step();
      if (bus0.gnt[ch]) seen[0] = 1;
      if (bus1.gnt[ch]) seen[1] = 1;
      for (int m = 0; m < 2; m++) if (e_gnt[m][ch]) req_d[m][ch] = 1'b0;
    end
    chk($sformatf("issue ch%0d seen dut0", ch), 32'(seen[0]), 32'd1);
    chk($sformatf("issue ch%0d seen dut1", ch), 32'(seen[1]), 32'd1);
    req_d[0][ch] = 1'b0; req_d[1][ch] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (cnt[0] > 0 || cnt[1] > 0); k++) begin
      for (int m = 0; m < 2; m++) begin
        rv_d[m] = (cnt[m] > 0);
        rdat_d[m] = DW'($urandom);
      end
      step();
    end
    rv_d[0] = 1'b0; rv_d[1] = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1;
    for (int m = 0; m < 2; m++) begin
      req_d[m] = '0; rw_d[m] = '0; addr_d[m] = '0; data_d[m] = '0;
      hp_d[m] = 1'b0; be_d[m] = 1'b1; rv_d[m] = 1'b0; rdat_d[m] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk50);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk50);
    reset = 1'b1;

    // Round-robin order 0,1,2,0 on dut1 from a fresh pointer.
    set_both(0, 1'b1, 1'b1, 20'h00A00, 16'h1000);
    set_both(1, 1'b1, 1'b1, 20'h00B00, 16'h2000);
    set_both(2, 1'b1, 1'b1, 20'h00C00, 16'h3000);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) chk("rr order dut1", 32'(bus1.gnt), 32'(3'b001 << ((k / 2) % 3)));
      else            chk("rr spacing dut1", 32'(bus1.gnt), 32'd0);
    end
    for (int c = 0; c < NCH; c++) set_both(c, 1'b0, 1'b0, '0, '0);
    repeat (2) step();

    // Fixed priority: channels 1 and 2 write continuously, dut0 serves only channel 1.
    set_both(1, 1'b1, 1'b1, 20'h11111, 16'hAAAA);
    set_both(2, 1'b1, 1'b1, 20'h22222, 16'hBBBB);
    g0 = 0; g1 = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      g0 += int'(bus0.gnt[1]);
      g1 += int'(bus0.gnt[2]);
    end
    chk("prio gnt1 count", 32'(g0), 32'd3);
    chk("prio gnt2 count", 32'(g1), 32'd0);
    chk("prio buf_addr", 32'(bus0.buf_addr), 32'h11111);
    set_both(1, 1'b0, 1'b0, '0, '0);
    set_both(2, 1'b0, 1'b0, '0, '0);
    repeat (2) step();

    // Display window excludes the CPU on dut0 until hp_en drops.
    hp_d[0] = 1'b1; hp_d[1] = 1'b1;
    set_both(1, 1'b1, 1'b1, 20'h00400, 16'h0123);
    g0 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      g0 += int'(bus0.gnt[1]);
    end
    chk("window gnt1 blocked", 32'(g0), 32'd0);
    hp_d[0] = 1'b0; hp_d[1] = 1'b0;
    step();
    chk("window gnt", 32'(bus0.gnt), 32'b010);
    chk("window wrreq", 32'(bus0.buf_wrreq), 32'd1);
    chk("window addr", 32'(bus0.buf_addr), 32'h00400);
    chk("window data", 32'(bus0.buf_data), 32'h0123);
    chk("window rw", 32'(bus0.buf_rw), 32'd1);
    set_both(1, 1'b0, 1'b0, '0, '0);
    repeat (2) step();
    drain();

    // Read routing: ch2 then ch0, data returns in issue order.
    issue_once(2, 1'b0, 20'h00222, 16'h0);
    issue_once(0, 1'b0, 20'h00111, 16'h0);
    step();
    rv_d[0] = 1'b1; rv_d[1] = 1'b1; rdat_d[0] = 16'hBEEF; rdat_d[1] = 16'hBEEF;
    step();
    chk("route first valid", 32'(bus0.rsp_valid), 32'b100);
    chk("route first data", 32'(bus0.rsp_data), 32'hBEEF);
    rdat_d[0] = 16'h1234; rdat_d[1] = 16'h1234;
    step();
    chk("route second valid", 32'(bus0.rsp_valid), 32'b001);
    chk("route second data", 32'(bus0.rsp_data), 32'h1234);
    rv_d[0] = 1'b0; rv_d[1] = 1'b0;
    step();
    chk("route idle valid", 32'(bus0.rsp_valid), 32'd0);

    // Tag FIFO full: reads blocked, writes still served; pop+push keeps occupancy.
    set_both(0, 1'b1, 1'b0, 20'h0A000, 16'h0);
    repeat (10) step();
    set_both(1, 1'b1, 1'b1, 20'h0B000, 16'h5555);
    g0 = 0; g1 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      g0 += int'(bus0.gnt[0]);
      g1 += int'(bus0.gnt[1]);
    end
    chk("full ch0 blocked", 32'(g0), 32'd0);
    chk("full ch1 served", 32'(g1), 32'd2);
    set_both(1, 1'b0, 1'b0, '0, '0);
    rv_d[0] = 1'b1; rv_d[1] = 1'b1; rdat_d[0] = 16'h0F0F; rdat_d[1] = 16'h0F0F;
    step();
    chk("full pop gnt none", 32'(bus0.gnt), 32'd0);
    step();
    chk("full push+pop gnt", 32'(bus0.gnt), 32'b001);
    chk("full push+pop rsp", 32'(bus0.rsp_valid), 32'b001);
    rv_d[0] = 1'b0; rv_d[1] = 1'b0;
    repeat (2) step();
    chk("full refill gnt", 32'(bus0.gnt), 32'b001);
    set_both(0, 1'b0, 1'b0, '0, '0);
    step();
    drain();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NCH; c++) begin
          if (req_d[m][c] && e_gnt[m][c]) begin
            if ($urandom_range(1, 0) == 0) req_d[m][c] = 1'b0;
            else set_req(m, c, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
          end else if (!req_d[m][c] && $urandom_range(9, 0) < 3) begin
            set_req(m, c, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
          end
        end
        if ($urandom_range(9, 0) == 0) hp_d[m] = !hp_d[m];
        be_d[m]   = ($urandom_range(4, 0) != 0);
        rv_d[m]   = (cnt[m] > 0) && ($urandom_range(2, 0) == 0);
        rdat_d[m] = DW'($urandom);
      end
      step();
    end
    for (int m = 0; m < 2; m++) begin
      req_d[m] = '0; hp_d[m] = 1'b0; be_d[m] = 1'b1;
    end
    repeat (2) step();
    drain();

    // Read with no tag outstanding sets the sticky error without a response.
    rv_d[0] = 1'b1; rv_d[1] = 1'b1; rdat_d[0] = 16'hDEAD; rdat_d[1] = 16'hDEAD;
    step();
    chk("err flag", 32'(bus0.rd_err), 32'd1);
    chk("err no rsp", 32'(bus0.rsp_valid), 32'd0);
    rv_d[0] = 1'b0; rv_d[1] = 1'b0;
    step();
    chk("err sticky", 32'(bus1.rd_err), 32'd1);

    // Reset in the middle of SETTLE with a read tag outstanding.
    set_both(0, 1'b1, 1'b0, 20'h0C0DE, 16'h0);
    step();
    chk("pre-reset gnt", 32'(bus0.gnt), 32'b001);
    set_both(0, 1'b0, 1'b0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async reset gnt", 32'(bus0.gnt), 32'd0);
    chk("async reset wrreq", 32'(bus0.buf_wrreq), 32'd0);
    chk("async reset err", 32'(bus0.rd_err), 32'd0);
    check_outputs(0);
    check_outputs(1);
    @(negedge clk50);
    reset = 1'b1;
    rv_d[0] = 1'b1; rv_d[1] = 1'b1;
    step();
    chk("tag discarded err", 32'(bus0.rd_err), 32'd1);
    chk("tag discarded rsp", 32'(bus1.rsp_valid), 32'd0);
    rv_d[0] = 1'b0; rv_d[1] = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
